mont_mul_fd: RTL

MONT_MUL_FD -- requirements
Module: mont_mul_fd

---
 rtl/mont_pkg.sv | 18 +
 rtl/mont_word_mac.sv | 16 +
 rtl/mont_mul_fd.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mont_pkg.sv
// Shared definitions for the fault-detecting Montgomery multiplier:
// FSM states, default widths and word-count helpers.
package mont_pkg;
  localparam int DEF_OP_WIDTH = 2048;
  localparam int DEF_WORD     = 64;

  typedef enum logic [2:0] {
    S_LOAD, S_MI, S_INNER, S_TOP, S_SUB, S_SWAP, S_CMP, S_OUT
  } mont_state_t;

  function automatic int nw_f(input int op_w, input int w);
    return op_w / w;
  endfunction

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/mont_word_mac.sv
// Combinational word MAC: a + x*y + p*q + c, full 2*WORD+1-bit result.
module mont_word_mac #(
  parameter int WORD = 64
) (
  input  logic [WORD-1:0]   a,
  input  logic [WORD-1:0]   x,
  input  logic [WORD-1:0]   y,
  input  logic [WORD-1:0]   p,
  input  logic [WORD-1:0]   q,
  input  logic [WORD:0]     c,
  output logic [2*WORD:0]   sum
);
  localparam int SW = 2 * WORD + 1;

  assign sum = SW'(a) + SW'(x) * SW'(y) + SW'(p) * SW'(q) + SW'(c);
endmodule

// File: rtl/mont_mul_fd.sv
// Word-serial CIOS Montgomery multiplier with optional duplicate-and-compare
// fault detection and a final result >= N range check.
module mont_mul_fd
  import mont_pkg::*;
#(
  parameter int OP_WIDTH = DEF_OP_WIDTH,
  parameter int WORD     = DEF_WORD
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [OP_WIDTH-1:0] modulus,
  input  logic [WORD-1:0]     n_prime,
  input  logic                check_en,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORD-1:0]     in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD-1:0]     out_data,
  output logic                out_last,
  output logic                fault,
  input  logic                inj_en
);
  localparam int NW = nw_f(OP_WIDTH, WORD);
  localparam int IW = cnt_w(NW);
  typedef logic [NW-1:0][WORD-1:0] vec_t;

  mont_state_t   state_q, state_d;
  logic [IW:0]   ld_q, ld_d;
  logic [IW-1:0] i_q, i_d, j_q, j_d;
  logic          lat_q, lat_d, chk_q, chk_d, pass2_q, pass2_d, bw_q, bw_d;
  logic          t_top_q, t_top_d;
  logic [WORD-1:0] m_q, m_d;
  logic [WORD:0]   c_q, c_d;
  vec_t t_q, t_d, u_q, u_d, v_q, v_d, d_q, d_d, p1_q, p1_d, r_q, r_d;
  logic          in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d, fault_q, fault_d;
  logic [WORD-1:0] out_data_q, out_data_d;

  vec_t            n_v, res;
  logic [WORD-1:0] mac_a, mac_x, mac_y, mac_p, mac_qn, mi_m, sum_lo;
  logic [WORD:0]   mac_c, sub_full;
  logic [2*WORD:0] mac_sum;
  logic [IW-1:0]   ld_off;
  logic            keep, ge_brw;

  assign n_v = modulus;

  always_comb begin
    mac_a  = t_q[j_q];
    mac_x  = u_q[i_q];
    mac_y  = v_q[j_q];
    mac_p  = m_q;
    mac_qn = n_v[j_q];
    mac_c  = c_q;
    if (state_q == S_MI) begin
      mac_a = t_q[0];
      mac_y = v_q[0];
      mac_p = '0;
      mac_c = '0;
    end else if (state_q == S_TOP) begin
      mac_a = WORD'(t_top_q);
      mac_x = '0;
      mac_p = '0;
    end
  end

  mont_word_mac #(.WORD(WORD)) u_mac (
    .a(mac_a), .x(mac_x), .y(mac_y), .p(mac_p), .q(mac_qn), .c(mac_c), .sum(mac_sum)
  );

  assign mi_m     = mac_sum[WORD-1:0] * n_prime;
  // Fault-injection hook only acts on the second pass's inner loop.
  assign sum_lo   = mac_sum[WORD-1:0] ^ WORD'(pass2_q & inj_en);
  assign sub_full = {1'b0, t_q[j_q]} - {1'b0, n_v[j_q]} - {{WORD{1'b0}}, bw_q};
  assign keep     = t_top_q | ~bw_q;
  assign res      = keep ? d_q : t_q;
  // Borrow of res - N: no borrow means the latched result is out of range.
  assign ge_brw   = (res < modulus);
  assign ld_off   = IW'(ld_q - (IW+1)'(NW));

  always_comb begin
    state_d = state_q;  ld_d = ld_q;  i_d = i_q;  j_d = j_q;  lat_d = lat_q;
    chk_d = chk_q;  pass2_d = pass2_q;  bw_d = bw_q;  t_top_d = t_top_q;
    m_d = m_q;  c_d = c_q;  t_d = t_q;  u_d = u_q;  v_d = v_q;  d_d = d_q;
    p1_d = p1_q;  r_d = r_q;
    in_ready_d = in_ready_q;  out_valid_d = out_valid_q;  out_last_d = out_last_q;
    out_data_d = out_data_q;  fault_d = fault_q;
    unique case (state_q)
      S_LOAD: if (in_valid && in_ready_q) begin
        if (ld_q == '0) chk_d = check_en;
        if (ld_q < (IW+1)'(NW)) u_d[ld_q[IW-1:0]] = in_data;
        else                    v_d[ld_off]       = in_data;
        if (ld_q == (IW+1)'(2*NW-1)) begin
          ld_d = '0;  in_ready_d = 1'b0;  state_d = S_MI;
          t_d = '0;  t_top_d = 1'b0;  i_d = '0;  j_d = '0;  pass2_d = 1'b0;
        end else ld_d = ld_q + 1'b1;
      end
      S_MI: begin
        m_d = mi_m;  j_d = '0;  c_d = '0;  state_d = S_INNER;
      end
      S_INNER: begin
        c_d = mac_sum[2*WORD:WORD];
        if (j_q != '0) t_d[j_q - 1'b1] = sum_lo;
        if (j_q == IW'(NW-1)) state_d = S_TOP;
        else                  j_d = j_q + 1'b1;
      end
      S_TOP: begin
        t_d[NW-1] = mac_sum[WORD-1:0];
        t_top_d   = mac_sum[WORD];
        j_d       = '0;
        if (i_q == IW'(NW-1)) begin
          state_d = S_SUB;  bw_d = 1'b0;  lat_d = 1'b0;
        end else begin
          i_d = i_q + 1'b1;  state_d = S_MI;
        end
      end
      S_SUB: if (!lat_q) begin
        d_d[j_q] = sub_full[WORD-1:0];
        bw_d     = sub_full[WORD];
        if (j_q == IW'(NW-1)) lat_d = 1'b1;
        else                  j_d = j_q + 1'b1;
      end else begin
        lat_d = 1'b0;  j_d = '0;  fault_d = fault_q | ~ge_brw;
        if (chk_q && !pass2_q) begin
          p1_d = res;  state_d = S_SWAP;
        end else begin
          r_d = res;
          if (chk_q) state_d = S_CMP;
          else begin
            state_d = S_OUT;  out_valid_d = 1'b1;  out_data_d = res[0];  out_last_d = 1'b0;
          end
        end
      end
      S_SWAP: begin
        t_d = '0;  t_top_d = 1'b0;  u_d = v_q;  v_d = u_q;
        i_d = '0;  pass2_d = 1'b1;  state_d = S_MI;
      end
      S_CMP: begin
        if (p1_q[j_q] != r_q[j_q]) fault_d = 1'b1;
        if (j_q == IW'(NW-1)) begin
          j_d = '0;  state_d = S_OUT;  out_valid_d = 1'b1;
          out_data_d = r_q[0];  out_last_d = 1'b0;
        end else j_d = j_q + 1'b1;
      end
      S_OUT: if (out_ready) begin
        if (j_q == IW'(NW-1)) begin
          state_d = S_LOAD;  j_d = '0;  in_ready_d = 1'b1;  out_valid_d = 1'b0;
          out_last_d = 1'b0;  out_data_d = '0;  fault_d = 1'b0;
        end else begin
          j_d        = j_q + 1'b1;
          out_data_d = r_q[IW'(j_q + 1'b1)];
          out_last_d = (IW'(j_q + 1'b1) == IW'(NW-1));
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_LOAD;  ld_q <= '0;  i_q <= '0;  j_q <= '0;  lat_q <= 1'b0;
      chk_q <= 1'b0;  pass2_q <= 1'b0;  bw_q <= 1'b0;  t_top_q <= 1'b0;
      m_q <= '0;  c_q <= '0;  t_q <= '0;  u_q <= '0;  v_q <= '0;  d_q <= '0;
      p1_q <= '0;  r_q <= '0;
      in_ready_q <= 1'b1;  out_valid_q <= 1'b0;  out_last_q <= 1'b0;
      out_data_q <= '0;  fault_q <= 1'b0;
    end else begin
      state_q <= state_d;  ld_q <= ld_d;  i_q <= i_d;  j_q <= j_d;  lat_q <= lat_d;
      chk_q <= chk_d;  pass2_q <= pass2_d;  bw_q <= bw_d;  t_top_q <= t_top_d;
      m_q <= m_d;  c_q <= c_d;  t_q <= t_d;  u_q <= u_d;  v_q <= v_d;  d_q <= d_d;
      p1_q <= p1_d;  r_q <= r_d;
      in_ready_q <= in_ready_d;  out_valid_q <= out_valid_d;  out_last_q <= out_last_d;
      out_data_q <= out_data_d;  fault_q <= fault_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign fault     = fault_q;
endmodule
